fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IR, next-PC selection and imem handshake
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wr,
    input  logic        ir_wr,
    input  logic [1:0]  npc_op,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        stall,
    output logic        fetch_err,
    output logic [31:0] pc,
    output logic [31:0] pc_link,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16
);

    typedef enum logic {IDLE, WAIT} state_t;

    // Last WAIT-state cycle that may still see ready before the fetch is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        pend_pc, pend_pc_nx;
    logic [31:0] pc_q, pc_nx;
    logic [31:0] ir_q;
    logic        err_q;
    logic        pc_load, ir_load, err_set, timeout_now;
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jr_aligned;

    assign pc_plus4   = pc_q + 32'd4;
    assign br_offset  = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign jr_aligned = jr_target & 32'hFFFF_FFFC;

    // State, counter, pending PC-write flag, PC, IR and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            pend_pc <= 1'b0;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend_pc <= pend_pc_nx;
            if (pc_load) pc_q <= pc_nx;
            if (ir_load) ir_q <= imem_rdata;
            if (err_set) err_q <= 1'b1;
        end
    end

    // Next-state, request and PC/IR load decisions for the fetch handshake.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pend_pc_nx  = pend_pc;
        pc_nx       = pc_q;
        pc_load     = 1'b0;
        ir_load     = 1'b0;
        err_set     = 1'b0;
        timeout_now = 1'b0;
        imem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (ir_wr) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_load = 1'b1;
                        if (pc_wr) begin
                            pc_load = 1'b1;
                            pc_nx   = pc_plus4;
                        end
                    end else begin
                        state_nx   = WAIT;
                        pend_pc_nx = pc_wr;
                        cnt_nx     = 8'd0;
                    end
                end else if (pc_wr) begin
                    pc_load = 1'b1;
                    case (npc_op)
                        2'b00:   pc_nx = pc_plus4;
                        2'b01:   pc_nx = pc_q + br_offset;
                        2'b10:   pc_nx = {pc_q[31:28], ir_q[25:0], 2'b00};
                        default: pc_nx = jr_aligned;
                    endcase
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load  = 1'b1;
                    state_nx = IDLE;
                    if (pend_pc) begin
                        pc_load = 1'b1;
                        pc_nx   = pc_plus4;
                    end
                end else if (cnt == CNT_LAST) begin
                    timeout_now = 1'b1;
                    err_set     = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign stall     = imem_req & ~imem_ready & ~timeout_now;
    assign fetch_err = err_q;
    assign pc        = pc_q;
    assign pc_link   = pc_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign imm16     = ir_q[15:0];
    assign func      = ir_q[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wr, ir_wr;
    logic [1:0]  npc_op;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall, fetch_err;
    logic [31:0] pc, pc_link, ir;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    int n_chk  = 0;
    int n_fail = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_op(npc_op),
        .jr_target(jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .fetch_err(fetch_err), .pc(pc), .pc_link(pc_link), .ir(ir), .op(op),
        .func(func), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_wr = 1'b0; ir_wr = 1'b0; npc_op = 2'b00;
        jr_target = 32'd0; imem_rdata = 32'd0; imem_ready = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_ir", ir, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // zero-wait fetch
        ir_wr = 1'b1; pc_wr = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h3402_0005;
        #1;
        chk("zw_req", {31'd0, imem_req}, 32'd1);
        chk("zw_stall", {31'd0, stall}, 32'd0);
        chk("zw_addr", imem_addr, 32'h0000_3000);
        tick();
        chk("zw_ir", ir, 32'h3402_0005);
        chk("zw_pc", pc, 32'h0000_3004);
        chk("zw_op", {26'd0, op}, 32'h0000_000D);
        chk("zw_rt", {27'd0, rt}, 32'd2);

        // three wait states, npc_op toggled while waiting
        imem_ready = 1'b0; imem_rdata = 32'h1000_FFFE;
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall) stall_cnt++;
            chk("w3_addr", imem_addr, 32'h0000_3004);
            tick();
            ir_wr = 1'b0; pc_wr = 1'b1; npc_op = 2'(i + 1);
        end
        imem_ready = 1'b1;
        #1;
        chk("w3_stall_last", {31'd0, stall}, 32'd0);
        chk("w3_pc_hold", pc, 32'h0000_3004);
        chk("w3_stall_cnt", stall_cnt, 32'd3);
        pc_wr = 1'b0;
        tick();
        imem_ready = 1'b0;
        chk("w3_pc", pc, 32'h0000_3008);
        chk("w3_ir", ir, 32'h1000_FFFE);
        chk("w3_imm", {16'd0, imm16}, 32'h0000_FFFE);

        // branch not taken then taken
        npc_op = 2'b01; pc_wr = 1'b0;
        tick();
        chk("br_nt", pc, 32'h0000_3008);
        pc_wr = 1'b1;
        tick();
        chk("br_t", pc, 32'h0000_3000);

        // jr to FFFFFFFC, then sequential fetch wraps to 0
        npc_op = 2'b11; jr_target = 32'hFFFF_FFFE;
        tick();
        chk("jr_hi", pc, 32'hFFFF_FFFC);
        ir_wr = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0000;
        tick();
        chk("wrap", pc, 32'h0000_0000);

        // jr to 3008, fetch jal-like word, jump, jr
        ir_wr = 1'b0; imem_ready = 1'b0; jr_target = 32'h0000_3008;
        tick();
        chk("jr_3008", pc, 32'h0000_3008);
        ir_wr = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0C00_0C10;
        tick();
        chk("j_ir", ir, 32'h0C00_0C10);
        ir_wr = 1'b0; imem_ready = 1'b0; npc_op = 2'b10;
        #1;
        chk("j_link", pc_link, 32'h0000_300C);
        tick();
        chk("j_pc", pc, 32'h0000_3040);
        npc_op = 2'b11; jr_target = 32'h0000_3017;
        tick();
        chk("jr_pc", pc, 32'h0000_3014);

        // timeout: ready never comes
        ir_wr = 1'b1; pc_wr = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        stall_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            #1;
            if (stall) stall_cnt++;
            if (i < 16) chk("to_err_low", {31'd0, fetch_err}, 32'd0);
            tick();
            ir_wr = 1'b0; pc_wr = 1'b0;
        end
        chk("to_stall_cnt", stall_cnt, 32'd16);
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_pc", pc, 32'h0000_3014);
        chk("to_ir", ir, 32'h0C00_0C10);
        chk("to_stall", {31'd0, stall}, 32'd0);
        chk("to_req", {31'd0, imem_req}, 32'd0);

        // reset during a later WAIT
        ir_wr = 1'b1; pc_wr = 1'b1;
        tick();
        ir_wr = 1'b0; pc_wr = 1'b0;
        tick();
        chk("mw_stall", {31'd0, stall}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req", {31'd0, imem_req}, 32'd0);
        chk("ar_stall", {31'd0, stall}, 32'd0);
        chk("ar_pc", pc, 32'h0000_3000);
        chk("ar_ir", ir, 32'd0);
        chk("ar_err", {31'd0, fetch_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
